// File: rtl/arb_rr_4req.sv
// arb_rr_4req: four-requester arbiter, fixed priority or round-robin, with a hold-time limit
module arb_rr_4req #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mode,
    input  logic [4:1]   r,
    output logic [4:1]   g,
    output logic [2:0]   y,
    output logic         busy,
    output logic         timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic [4:1]       mask;
    logic [3:0]       elig;
    logic             found;

    assign elig = r & ~mask;

    // winner search: descending from 4 (fixed) or from last-1 wrapping back to last (round-robin)
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = mode ? last - 2'(i) : 2'(4 - i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // ownership FSM: grant, hold until release, revoke at the hold limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            g       <= '0;
            y       <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            last    <= 2'd0;
            mask    <= '0;
        end else if (state == IDLE) begin
            timeout <= 1'b0;
            mask    <= '0;
            if (found) begin
                state <= GRANT;
                g     <= 4'b0001 << win;
                y     <= {1'b0, win} + 3'd1;
                busy  <= 1'b1;
                cnt   <= '0;
                last  <= win;
            end
        end else if ((g & r) == '0) begin
            state <= IDLE;
            g     <= '0;
            y     <= '0;
            busy  <= 1'b0;
        end else if (cnt == CNT_W'(HOLD_MAX - 1)) begin
            state   <= IDLE;
            g       <= '0;
            y       <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            mask    <= g;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_arb_rr_4req.sv
// tb_arb_rr_4req: scoreboard bench for the four-requester arbiter
module tb_arb_rr_4req;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode = 1'b0;
    logic [4:1] r = '0;
    logic [4:1] g;
    logic [2:0] y;
    logic       busy;
    logic       timeout;
    int         errors = 0;
    int         checks = 0;
    logic [8:0] q[$];

    typedef struct packed {
        logic [3:0] r;
        logic       m;
        logic [3:0] g;
        logic       t;
    } stim_t;

    arb_rr_4req #(.HOLD_MAX(4), .CNT_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .r(r),
        .g(g), .y(y), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ex(input logic [3:0] gg, input logic t);
        logic [2:0] yy;
        yy = gg[3] ? 3'b100 : gg[2] ? 3'b011 : gg[1] ? 3'b010 : gg[0] ? 3'b001 : 3'b000;
        return {gg, yy, |gg, t};
    endfunction

    function automatic stim_t mk(input logic [3:0] rr, input logic m, input logic [3:0] gg, input logic t);
        stim_t s;
        s.r = rr;
        s.m = m;
        s.g = gg;
        s.t = t;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        r    = s.r;
        mode = s.m;
        q.push_back(ex(s.g, s.t));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        stim_t s[$];
        reset_n = 1'b0;
        r = '0;
        mode = 1'b0;
        q.push_back(ex(4'b0000, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({g, y, busy, timeout} !== e) begin
            errors++;
            $display("FAIL reset_state: g=%b y=%b busy=%b timeout=%b, expected %b", g, y, busy, timeout, e);
        end
        reset_n = 1'b1;
        drive(mk(4'b0100, 1'b0, 4'b0100, 1'b0));
        e = q.pop_front();
        checks++;
        if ({g, y, busy, timeout} !== e) begin
            errors++;
            $display("FAIL reset_pre_grant: g=%b y=%b busy=%b timeout=%b, expected %b", g, y, busy, timeout, e);
        end
        reset_n = 1'b0;
        q.push_back(ex(4'b0000, 1'b0));
        #2;
        e = q.pop_front();
        checks++;
        if ({g, y, busy, timeout} !== e) begin
            errors++;
            $display("FAIL reset_async: g=%b y=%b busy=%b timeout=%b, expected %b", g, y, busy, timeout, e);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        s.push_back(mk(4'b1111, 1'b0, 4'b1000, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            checks++;
            if ({g, y, busy, timeout} !== e) begin
                errors++;
                $display("FAIL reset_after[%0d]: g=%b y=%b busy=%b timeout=%b, expected %b", i, g, y, busy, timeout, e);
            end
        end
    endtask

    task automatic test_fixed();
        logic [8:0] e;
        stim_t s[$];
        s.push_back(mk(4'b0110, 1'b0, 4'b0100, 1'b0));
        s.push_back(mk(4'b0110, 1'b0, 4'b0100, 1'b0));
        s.push_back(mk(4'b0010, 1'b0, 4'b0000, 1'b0));
        s.push_back(mk(4'b0010, 1'b0, 4'b0010, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            checks++;
            if ({g, y, busy, timeout} !== e) begin
                errors++;
                $display("FAIL fixed[%0d]: g=%b y=%b busy=%b timeout=%b, expected %b", i, g, y, busy, timeout, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] e;
        logic [3:0] k;
        stim_t s[$];
        s.push_back(mk(4'b0001, 1'b0, 4'b0001, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        for (int n = 0; n < 5; n++) begin
            k = 4'b1000 >> (n % 4);
            repeat (3) s.push_back(mk(4'b1111, 1'b1, k, 1'b0));
            s.push_back(mk(4'b1111 & ~k, 1'b1, 4'b0000, 1'b0));
        end
        s.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            checks++;
            if ({g, y, busy, timeout} !== e) begin
                errors++;
                $display("FAIL rr[%0d]: g=%b y=%b busy=%b timeout=%b, expected %b", i, g, y, busy, timeout, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        stim_t s[$];
        repeat (4) s.push_back(mk(4'b1001, 1'b0, 4'b1000, 1'b0));
        s.push_back(mk(4'b1001, 1'b0, 4'b0000, 1'b1));
        s.push_back(mk(4'b1001, 1'b0, 4'b0001, 1'b0));
        s.push_back(mk(4'b1001, 1'b0, 4'b0001, 1'b0));
        s.push_back(mk(4'b1000, 1'b0, 4'b0000, 1'b0));
        s.push_back(mk(4'b1000, 1'b0, 4'b1000, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            checks++;
            if ({g, y, busy, timeout} !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: g=%b y=%b busy=%b timeout=%b, expected %b", i, g, y, busy, timeout, e);
            end
        end
    endtask

    task automatic test_release_vs_timeout();
        logic [8:0] e;
        stim_t s[$];
        repeat (4) s.push_back(mk(4'b1001, 1'b0, 4'b1000, 1'b0));
        s.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0));
        s.push_back(mk(4'b1001, 1'b0, 4'b1000, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        s.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            checks++;
            if ({g, y, busy, timeout} !== e) begin
                errors++;
                $display("FAIL release_vs_timeout[%0d]: g=%b y=%b busy=%b timeout=%b, expected %b", i, g, y, busy, timeout, e);
            end
        end
    endtask

    task automatic test_mode_idle();
        logic [8:0] e;
        stim_t s[$];
        s.push_back(mk(4'b0011, 1'b0, 4'b0010, 1'b0));
        s.push_back(mk(4'b0011, 1'b1, 4'b0010, 1'b0));
        s.push_back(mk(4'b0011, 1'b0, 4'b0010, 1'b0));
        s.push_back(mk(4'b0001, 1'b1, 4'b0000, 1'b0));
        s.push_back(mk(4'b0011, 1'b1, 4'b0001, 1'b0));
        s.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0));
        repeat (5) s.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0));
        foreach (s[i]) begin
            drive(s[i]);
            e = q.pop_front();
            checks++;
            if ({g, y, busy, timeout} !== e) begin
                errors++;
                $display("FAIL mode_idle[%0d]: g=%b y=%b busy=%b timeout=%b, expected %b", i, g, y, busy, timeout, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_timeout();
        test_release_vs_timeout();
        test_mode_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arb_rr_4req.md
# arb_rr_4req

Four-requester bus arbiter that shares one resource among requesters r[4:1]. It selects a winner by fixed priority (r[4] highest) or by round-robin, and holds the grant until the owner drops its request. It also enforces a maximum hold time. Its encoded owner output y uses the same 3-bit code as the team's 4-input priority encoder (100, 011, 010, 001, 000 for none), so it can replace that encoder where ownership must persist across cycles.

## Interface
- HOLD_MAX, 16: maximum consecutive grant cycles per ownership; legal range 2..(2^CNT_W − 1).
- CNT_W, 5: width of the hold counter.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- r  in  [4:1]  request lines; a requester holds its bit high for the whole transaction.
- g  out  [4:1]  one-hot grant, registered; all-zero when idle.
- y  out  [2:0]  encoded owner, registered with g: r4→100, r3→011, r2→010, r1→001, none→000.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

## Operation
- **Reset values:** state IDLE, g=0000, y=000, busy=0, timeout=0, hold counter=0, last-owner pointer=1, mask=0000.
- **States:** IDLE and GRANT.
- **IDLE:**
  - Arbitrates over the eligible set, which is r & ~mask.
  - If the set is non-empty, the next edge loads g and y for the winner, sets busy=1, clears the counter, updates last-owner to the winner, clears mask, and enters GRANT.
  - If the set is empty, stay in IDLE and clear mask.
- **Fixed priority (mode=0):** search order is 4,3,2,1.
- **Round-robin (mode=1):** search starts at last−1 and descends, wrapping 1→4, ending at last.
  - With last=1 at reset, the first search order is 4,3,2,1.
  - last-owner updates on every grant in both modes, so switching to mode 1 continues rotation from the most recent owner.
- **GRANT, owner k, priority order of checks:**
  - **Release:** r[k]=0 at the edge. Next edge: g=0, y=000, busy=0, state IDLE, no timeout.
  - **Timeout:** r[k]=1 and counter = HOLD_MAX−1. Next edge: g=0, y=000, busy=0, timeout=1 for one cycle, mask = one-hot k, state IDLE.
  - **Continue:** otherwise the counter increments and g holds.
- **Release wins over timeout:** if release and timeout coincide on the same edge, treat it as a release (no pulse, no mask).
- **Mask:** the masked requester is excluded from the next IDLE arbitration only, in both modes.
- **Non-owner requests:** requests from non-owners during GRANT are ignored; they are not latched or queued.
- **mode in GRANT:** changes to mode during GRANT have no effect until IDLE.
- **reset_n mid-grant:** asserting reset_n low at any time forces all reset values immediately, without waiting for an edge; g drops combinationally via the async clear.

## Timing
- **Request-to-grant latency:** 1 cycle. A request seen high at edge n (in IDLE) produces g at edge n+1.
- **Release-to-deassert:** g deasserts 1 edge after r[k] falls.
- **Back-to-back grants:** every ownership is followed by exactly one IDLE cycle with g=0000.
- **Grant-to-grant spacing:** minimum 2 cycles from one grant edge to the next.
- **Maximum continuous ownership:** HOLD_MAX cycles of g high. The timeout pulse coincides with the first g=0 cycle.
- **Output invariants:** g is never multi-hot, and y always equals the encoding of g.
- **Counter:** never wraps, because the timeout fires at HOLD_MAX−1. No arithmetic wider than CNT_W.

## Test plan
- **Reset:**
  - Stimulus: assert reset_n=0 mid-grant (g=0100).
  - Required: g=0000, y=000, busy=0 immediately.
  - After release with r=1111, mode=0: first grant g=1000, y=100.
- **Fixed priority with release:**
  - Stimulus: mode=0, r=0110.
  - Required: g=0100, y=011.
  - Then drop r[3]: 1 idle cycle, then g=0010, y=010.
- **Round-robin rotation:**
  - Stimulus: mode=1, r=1111, each owner releases after 3 cycles.
  - Required: grant sequence 4,3,2,1,4, each grant separated by one g=0000 cycle.
- **Timeout:**
  - Stimulus: HOLD_MAX=4, mode=0, r=1001 held high.
  - Required: g=1000 for exactly 4 cycles, then timeout=1 with g=0000, then g=0001 (r4 masked).
  - After r1 releases: g=1000 again.
- **Simultaneous release and timeout:**
  - Stimulus: r[k] drops on the same edge the counter hits HOLD_MAX−1.
  - Required: timeout stays 0 and the next arbitration is unmasked.
- **Mode change and idle:**
  - Stimulus: toggle mode during GRANT.
  - Required: the current grant is unaffected, and the new mode applies at the next IDLE.
  - With r=0000: busy=0 and y=000 indefinitely.
